// File: rtl/pc_pkg.sv
// pc_pkg: shared types for the fetch-stage PC controller.
//   redirect_kind_e : redirect priority, numerically ordered (EXC highest).
//   pc_state_e      : controller FSM state.
//   redirect_t      : kind/target pair (32-bit target view).
//   kind_ge()       : true when kind a has priority >= kind b.
package pc_pkg;

  typedef enum logic [1:0] {
    RK_NONE = 2'd0,
    RK_BR   = 2'd1,
    RK_ERET = 2'd2,
    RK_EXC  = 2'd3
  } redirect_kind_e;

  typedef enum logic {
    PC_BOOT = 1'b0,
    PC_RUN  = 1'b1
  } pc_state_e;

  typedef struct packed {
    redirect_kind_e kind;
    logic [31:0]    target;
  } redirect_t;

  function automatic logic kind_ge(input redirect_kind_e a, input redirect_kind_e b);
    return (a >= b);
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// pc_redirect_arb: combinational redirect arbitration.
//   Picks the incoming redirect (exc > eret > br), then chooses between it
//   and the buffered (pending) redirect. On equal kinds the incoming one
//   wins because it carries the newer target.
// Ports:
//   exc_valid, eret_valid, eret_target, br_valid, br_target : sources
//   pend_kind, pend_target : buffered redirect
//   eff_kind, eff_target   : effective redirect this cycle
module pc_redirect_arb
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic           exc_valid,
  input  logic           eret_valid,
  input  logic [WIDTH-1:0] eret_target,
  input  logic           br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  redirect_kind_e pend_kind,
  input  logic [WIDTH-1:0] pend_target,
  output redirect_kind_e eff_kind,
  output logic [WIDTH-1:0] eff_target
);

  redirect_kind_e   inc_kind;
  logic [WIDTH-1:0] inc_target;

  always_comb begin
    inc_kind   = RK_NONE;
    inc_target = '0;
    if (exc_valid) begin
      inc_kind   = RK_EXC;
      inc_target = EXC_VECTOR;
    end else if (eret_valid) begin
      inc_kind   = RK_ERET;
      inc_target = eret_target;
    end else if (br_valid) begin
      inc_kind   = RK_BR;
      inc_target = br_target;
    end
  end

  always_comb begin
    eff_kind   = pend_kind;
    eff_target = pend_target;
    if (kind_ge(inc_kind, pend_kind)) begin
      eff_kind   = inc_kind;
      eff_target = inc_target;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-stage program-counter controller.
//   Holds the fetch PC, drives the imem request, applies prioritised
//   redirects and buffers one redirect while fetch cannot advance.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   stall               : pipeline hazard hold (overridden by exceptions)
//   if_ready            : imem accepts the request this cycle
//   exc_valid           : exception redirect to EXC_VECTOR
//   eret_valid/_target  : eret redirect
//   br_valid/_target    : branch/jump redirect
//   pc                  : current fetch address
//   if_req              : fetch request valid
//   redirect_pending    : a buffered redirect is held
//   pc_adel             : pc is not word aligned
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned      STEP         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             if_ready,
  input  logic             exc_valid,
  input  logic             eret_valid,
  input  logic [WIDTH-1:0] eret_target,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  output logic [WIDTH-1:0] pc,
  output logic             if_req,
  output logic             redirect_pending,
  output logic             pc_adel
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  pc_state_e        state;
  redirect_kind_e   pend_kind;
  logic [WIDTH-1:0] pend_target;
  redirect_kind_e   eff_kind;
  logic [WIDTH-1:0] eff_target;
  logic             adv;

  pc_redirect_arb #(
    .WIDTH      (WIDTH),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_arb (
    .exc_valid   (exc_valid),
    .eret_valid  (eret_valid),
    .eret_target (eret_target),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .pend_kind   (pend_kind),
    .pend_target (pend_target),
    .eff_kind    (eff_kind),
    .eff_target  (eff_target)
  );

  // Exceptions bypass the hazard stall but still respect imem back-pressure.
  assign adv = if_req & if_ready & (~stall | (eff_kind == RK_EXC));

  // if_req is only low in BOOT, so adv is never set there; a redirect seen
  // in BOOT therefore falls into the buffering branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PC_BOOT;
      pc          <= RESET_VECTOR;
      if_req      <= 1'b0;
      pend_kind   <= RK_NONE;
      pend_target <= '0;
    end else begin
      case (state)
        PC_BOOT: begin
          state  <= PC_RUN;
          if_req <= 1'b1;
        end
        default: begin
          state  <= PC_RUN;
          if_req <= 1'b1;
        end
      endcase
      if (adv) begin
        pc          <= (eff_kind != RK_NONE) ? eff_target : pc + STEP_W;
        pend_kind   <= RK_NONE;
        pend_target <= '0;
      end else if (eff_kind != RK_NONE) begin
        pend_kind   <= eff_kind;
        pend_target <= eff_target;
      end
    end
  end

  assign redirect_pending = (pend_kind != RK_NONE);
  assign pc_adel          = (pc[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        if_ready;
  logic        exc_valid;
  logic        eret_valid;
  logic [31:0] eret_target;
  logic        br_valid;
  logic [31:0] br_target;
  logic [31:0] pc;
  logic        if_req;
  logic        redirect_pending;
  logic        pc_adel;

  pc_ctrl #(
    .WIDTH        (32),
    .RESET_VECTOR (32'hBFC0_0000),
    .EXC_VECTOR   (32'hBFC0_0380),
    .STEP         (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .if_ready         (if_ready),
    .exc_valid        (exc_valid),
    .eret_valid       (eret_valid),
    .eret_target      (eret_target),
    .br_valid         (br_valid),
    .br_target        (br_target),
    .pc               (pc),
    .if_req           (if_req),
    .redirect_pending (redirect_pending),
    .pc_adel          (pc_adel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          tag;
    logic [31:0] pc;
    logic        req;
    logic        pend;
    logic        adel;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_run  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation tagged for the cycle just clocked.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tag <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_run++;
      if (e.tag != cyc) begin
        n_fail++;
        $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.name, e.tag, cyc);
      end else if (pc !== e.pc || if_req !== e.req || redirect_pending !== e.pend || pc_adel !== e.adel) begin
        n_fail++;
        $display("FAIL %s: got pc=%h req=%b pend=%b adel=%b, want pc=%h req=%b pend=%b adel=%b",
                 e.name, pc, if_req, redirect_pending, pc_adel, e.pc, e.req, e.pend, e.adel);
      end
    end
  end

  task automatic set_in(input logic r, input logic st, input logic rdy,
                        input logic ex, input logic er, input logic [31:0] et,
                        input logic br, input logic [31:0] bt);
    rst = r; stall = st; if_ready = rdy;
    exc_valid = ex; eret_valid = er; eret_target = et;
    br_valid = br; br_target = bt;
  endtask

  // Push the state expected after the coming edge, then clock it.
  task automatic expect_tick(input logic [31:0] epc, input logic ereq,
                             input logic epend, input string nm);
    exp_t e;
    e.tag  = cyc + 1;
    e.pc   = epc;
    e.req  = ereq;
    e.pend = epend;
    e.adel = (epc[1:0] != 2'b00);
    e.name = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(1, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    @(posedge clk); #1;
    expect_tick(32'hBFC0_0000, 0, 0, "reset");

    // Boot sequence
    set_in(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    expect_tick(32'hBFC0_0000, 1, 0, "boot_to_run");
    expect_tick(32'hBFC0_0004, 1, 0, "seq_1");
    expect_tick(32'hBFC0_0008, 1, 0, "seq_2");

    // Branch under stall is buffered then applied
    set_in(0, 1, 1, 0, 0, 32'h0, 1, 32'h8000_0100);
    expect_tick(32'hBFC0_0008, 1, 1, "br_stall_hold");
    set_in(0, 1, 1, 0, 0, 32'h0, 0, 32'h0);
    expect_tick(32'hBFC0_0008, 1, 1, "br_stall_keep");
    set_in(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    expect_tick(32'h8000_0100, 1, 0, "br_release");
    expect_tick(32'h8000_0104, 1, 0, "br_seq");

    // BR, ERET, BR under stall: ERET outranks the later BR
    set_in(0, 1, 1, 0, 0, 32'h0, 1, 32'h8000_0100);
    expect_tick(32'h8000_0104, 1, 1, "prio_br");
    set_in(0, 1, 1, 0, 1, 32'h8000_0200, 0, 32'h0);
    expect_tick(32'h8000_0104, 1, 1, "prio_eret");
    set_in(0, 1, 1, 0, 0, 32'h0, 1, 32'h8000_0300);
    expect_tick(32'h8000_0104, 1, 1, "prio_br2");
    set_in(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    expect_tick(32'h8000_0200, 1, 0, "prio_release");
    expect_tick(32'h8000_0204, 1, 0, "prio_seq");

    // Exception overrides stall
    set_in(0, 1, 1, 1, 0, 32'h0, 0, 32'h0);
    expect_tick(32'hBFC0_0380, 1, 0, "exc_over_stall");
    set_in(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    expect_tick(32'hBFC0_0384, 1, 0, "exc_seq");
    set_in(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    expect_tick(32'hBFC0_0384, 1, 0, "backpressure_hold");

    // Exception under back-pressure is buffered; later BR does not displace it
    set_in(0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
    expect_tick(32'hBFC0_0384, 1, 1, "exc_bp_hold");
    set_in(0, 0, 0, 0, 0, 32'h0, 1, 32'h8000_0100);
    expect_tick(32'hBFC0_0384, 1, 1, "exc_keep_vs_br");
    set_in(0, 1, 1, 0, 0, 32'h0, 0, 32'h0);
    expect_tick(32'hBFC0_0380, 1, 0, "exc_pend_apply");

    // All three at once: only EXC taken
    set_in(0, 0, 1, 1, 1, 32'h8000_0200, 1, 32'h8000_0300);
    expect_tick(32'hBFC0_0380, 1, 0, "simul_exc");
    set_in(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    expect_tick(32'hBFC0_0384, 1, 0, "simul_no_queue");

    // Wrap and misalignment
    set_in(0, 0, 1, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
    expect_tick(32'hFFFF_FFFC, 1, 0, "wrap_jump");
    set_in(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    expect_tick(32'h0000_0000, 1, 0, "wrap_zero");
    set_in(0, 0, 1, 0, 0, 32'h0, 1, 32'h8000_0102);
    expect_tick(32'h8000_0102, 1, 0, "adel_jump");
    set_in(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    expect_tick(32'h8000_0106, 1, 0, "adel_seq");

    // Reset drops a pending redirect
    set_in(0, 1, 1, 0, 0, 32'h0, 1, 32'h8000_0100);
    expect_tick(32'h8000_0106, 1, 1, "rst_pre_pend");
    set_in(1, 1, 1, 0, 0, 32'h0, 1, 32'h8000_0200);
    expect_tick(32'hBFC0_0000, 0, 0, "rst_drop");
    set_in(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    expect_tick(32'hBFC0_0000, 1, 0, "rst_boot");
    expect_tick(32'hBFC0_0004, 1, 0, "rst_seq");

    // Redirect during BOOT is applied on first RUN advance
    set_in(1, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    expect_tick(32'hBFC0_0000, 0, 0, "reset2");
    set_in(0, 0, 1, 0, 0, 32'h0, 1, 32'h8000_0100);
    expect_tick(32'hBFC0_0000, 1, 1, "boot_redirect");
    set_in(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    expect_tick(32'h8000_0100, 1, 0, "boot_redirect_apply");

    @(negedge clk);
    #1;
    n_run++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
